// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith/compare ops, serial
// one-bit-per-cycle shifts, valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic             ShiftArith,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work_reg;
  logic [SW-1:0]    count;
  logic             dir_left;
  logic             arith;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;

  logic             accept;
  logic             is_shift;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] shift_next;

  assign accept   = in_valid && (state == IDLE);
  assign is_shift = (ALUControl == 4'b0010) || (ALUControl == 4'b0110);
  assign shamt    = SrcB[SW-1:0];

  always_comb begin
    op_result = '0;
    case (ALUControl)
      4'b0000: op_result = SrcA + SrcB;
      4'b0001: op_result = SrcA - SrcB;
      4'b0011: op_result = WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b0100: op_result = WIDTH'(SrcA < SrcB);
      4'b0101: op_result = SrcA ^ SrcB;
      4'b1000: op_result = SrcA | SrcB;
      4'b1001: op_result = SrcA & SrcB;
      default: op_result = '0;
    endcase
  end

  // SRA refills the MSB with its current value; SLL/SRL refill with zero
  always_comb begin
    shift_next = '0;
    if (dir_left)
      shift_next = {work_reg[WIDTH-2:0], 1'b0};
    else
      shift_next = {arith & work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept)
          state_next = (is_shift && (shamt != '0)) ? SHIFT : DONE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == SW'(1))
          state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only move when a result is produced, so they hold in DONE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work_reg   <= '0;
      count      <= '0;
      dir_left   <= 1'b0;
      arith      <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift) begin
              work_reg <= SrcA;
              count    <= shamt;
              dir_left <= (ALUControl == 4'b0010);
              arith    <= ShiftArith;
              if (shamt == '0) begin
                result_reg <= SrcA;
                zero_reg   <= (SrcA == '0);
              end
            end else begin
              result_reg <= op_result;
              zero_reg   <= (op_result == '0);
            end
          end
        end
        SHIFT: begin
          work_reg <= shift_next;
          count    <= count - SW'(1);
          if (count == SW'(1)) begin
            result_reg <= shift_next;
            zero_reg   <= (shift_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign ALUResult = result_reg;
  assign Zero      = zero_reg;

endmodule
